// File: rtl/accel_job_sequencer.sv
// rtl/accel_job_sequencer.sv - walks a descriptor chain, programs the accelerator per job, one irq per batch
module accel_job_sequencer
  #(parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [4:0]  acc_address,
    output logic        acc_write,
    output logic [31:0] acc_writedata,
    input  logic        acc_irq,
    output logic        irq
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_PROG, S_START, S_WAIT_IRQ, S_ACK, S_DRAIN, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] base_q, base_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] jobs_q, jobs_d;
    logic [2:0]  w_q, w_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        avm_read_q, avm_read_d;
    logic [31:0] avm_address_q, avm_address_d;
    logic        acc_write_q, acc_write_d;
    logic [4:0]  acc_address_q, acc_address_d;
    logic [31:0] acc_writedata_q, acc_writedata_d;
    logic        irq_q, irq_d;
    logic        wr_base, wr_count, wr_ctrl, start, timeout;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^avs_address[1:0];
    assign wr_base  = avs_write && (avs_address[3:2] == 2'd0);
    assign wr_count = avs_write && (avs_address[3:2] == 2'd1);
    assign wr_ctrl  = avs_write && (avs_address[3:2] == 2'd2);
    assign start    = wr_ctrl && avs_writedata[0] && !busy_q;

    function automatic logic [31:0] desc_addr(input logic [29:0] base, input logic [15:0] i,
                                              input logic [2:0] w);
        desc_addr = {base, 2'b00} + {11'd0, i, 5'd0} + {27'd0, w, 2'b00};
    endfunction

`ifdef ACCEL_SEQ_TIMEOUT_EN
    logic        waiting;
    logic [31:0] tmo_q, tmo_d;
    assign waiting = (state_q == S_WAIT_IRQ) || (state_q == S_DRAIN);
    assign timeout = waiting && (tmo_q == TIMEOUT_CYCLES - 32'd1);
    always_comb tmo_d = waiting ? tmo_q + 32'd1 : 32'd0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmo_q <= 32'd0;
        else          tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        count_d         = count_q;
        idx_d           = idx_q;
        jobs_d          = jobs_q;
        w_d             = w_q;
        irq_en_d        = irq_en_q;
        done_d          = done_q;
        err_d           = err_q;
        busy_d          = busy_q;
        avm_read_d      = 1'b0;
        avm_address_d   = avm_address_q;
        acc_write_d     = 1'b0;
        acc_address_d   = acc_address_q;
        acc_writedata_d = acc_writedata_q;

        if (wr_base && !busy_q)  base_d  = avs_writedata[31:2];
        if (wr_count && !busy_q) count_d = avs_writedata[15:0];
        if (wr_ctrl) begin
            irq_en_d = avs_writedata[1];
            done_d   = 1'b0;
            err_d    = 1'b0;
        end

        unique case (state_q)
            S_IDLE: if (start) begin
                busy_d = 1'b1;
                jobs_d = 16'd0;
                idx_d  = 16'd0;
                w_d    = 3'd0;
                if (count_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d       = S_FETCH;
                    avm_read_d    = 1'b1;
                    avm_address_d = desc_addr(base_q, 16'd0, 3'd0);
                end
            end
            S_FETCH: begin
                if (avm_waitrequest) begin
                    avm_read_d = 1'b1;
                end else begin
                    state_d         = S_PROG;
                    acc_write_d     = 1'b1;
                    acc_address_d   = {w_q, 2'b00};
                    acc_writedata_d = avm_readdata;
                end
            end
            S_PROG: begin
                if (w_q != 3'd6) begin
                    w_d           = w_q + 3'd1;
                    state_d       = S_FETCH;
                    avm_read_d    = 1'b1;
                    avm_address_d = desc_addr(base_q, idx_q, w_q + 3'd1);
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d         = S_WAIT_IRQ;
                acc_write_d     = 1'b1;
                acc_address_d   = 5'h1C;
                acc_writedata_d = 32'd1;
            end
            S_WAIT_IRQ: if (acc_irq && !acc_write_q) begin
                state_d         = S_ACK;
                acc_write_d     = 1'b1;
                acc_address_d   = 5'h1C;
                acc_writedata_d = 32'd0;
            end
            S_ACK: begin
                jobs_d  = jobs_q + 16'd1;
                state_d = S_DRAIN;
            end
            S_DRAIN: if (!acc_irq) begin
                if (({1'b0, idx_q} + 17'd1) < {1'b0, count_q}) begin
                    idx_d         = idx_q + 16'd1;
                    w_d           = 3'd0;
                    state_d       = S_FETCH;
                    avm_read_d    = 1'b1;
                    avm_address_d = desc_addr(base_q, idx_q + 16'd1, 3'd0);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            done_d          = 1'b1;
            err_d           = 1'b1;
            busy_d          = 1'b0;
            state_d         = S_IDLE;
            acc_write_d     = 1'b1;
            acc_address_d   = 5'h1C;
            acc_writedata_d = 32'd0;
        end

        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            base_q          <= 30'd0;
            count_q         <= 16'd0;
            idx_q           <= 16'd0;
            jobs_q          <= 16'd0;
            w_q             <= 3'd0;
            irq_en_q        <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            busy_q          <= 1'b0;
            avm_read_q      <= 1'b0;
            avm_address_q   <= 32'd0;
            acc_write_q     <= 1'b0;
            acc_address_q   <= 5'd0;
            acc_writedata_q <= 32'd0;
            irq_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            count_q         <= count_d;
            idx_q           <= idx_d;
            jobs_q          <= jobs_d;
            w_q             <= w_d;
            irq_en_q        <= irq_en_d;
            done_q          <= done_d;
            err_q           <= err_d;
            busy_q          <= busy_d;
            avm_read_q      <= avm_read_d;
            avm_address_q   <= avm_address_d;
            acc_write_q     <= acc_write_d;
            acc_address_q   <= acc_address_d;
            acc_writedata_q <= acc_writedata_d;
            irq_q           <= irq_d;
        end
    end

    always_comb begin
        case (avs_address[3:2])
            2'd0:    avs_readdata = {base_q, 2'b00};
            2'd1:    avs_readdata = {16'd0, count_q};
            2'd2:    avs_readdata = {30'd0, irq_en_q, 1'b0};
            default: avs_readdata = {jobs_q, 13'd0, err_q, done_q, busy_q};
        endcase
    end

    assign avm_read      = avm_read_q;
    assign avm_address   = avm_address_q;
    assign acc_write     = acc_write_q;
    assign acc_address   = acc_address_q;
    assign acc_writedata = acc_writedata_q;
    assign irq           = irq_q;
endmodule

// File: tb/tb_accel_job_sequencer.sv
// tb/tb_accel_job_sequencer.sv - scoreboard bench for accel_job_sequencer
`timescale 1ns/1ps
module tb_accel_job_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic [31:0] avm_address;
    logic        avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [4:0]  acc_address;
    logic        acc_write;
    logic [31:0] acc_writedata;
    logic        acc_irq, irq;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wait_states = 0;
    int irq_delay   = 50;
    bit irq_never   = 1'b0;
    int viol_back2back = 0, viol_overlap = 0, viol_fetch_irq = 0;

    logic [36:0] exp_acc[$];
    logic [31:0] exp_avm[$];
    bit [31:0]   mem [bit [31:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    accel_job_sequencer #(.TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .acc_address(acc_address), .acc_write(acc_write),
        .acc_writedata(acc_writedata), .acc_irq(acc_irq), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    initial begin : avm_slave
        int stalls;
        stalls = 0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (reset_n && avm_read) begin
                if (stalls < wait_states) begin
                    avm_waitrequest = 1'b1;
                    stalls++;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata = mem.exists(avm_address) ? mem[avm_address] : 32'hDEAD_DEAD;
                    stalls = 0;
                end
            end else begin
                avm_waitrequest = 1'b0;
                stalls = 0;
            end
        end
    end

    initial begin : acc_model
        int cnt;
        cnt = 0;
        acc_irq = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) cnt = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) acc_irq = 1'b1;
            end
            if (reset_n && acc_write && acc_address == 5'h1C) begin
                if (acc_writedata == 32'd1 && !irq_never) cnt = irq_delay;
                else if (acc_writedata == 32'd0) acc_irq = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit prev_wr, prev_stall;
        logic [31:0] stall_addr;
        int last_accept;
        logic [36:0] e;
        prev_wr = 1'b0; prev_stall = 1'b0; stall_addr = 32'd0; last_accept = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_wr = 1'b0;
                prev_stall = 1'b0;
                continue;
            end
            if (acc_write && prev_wr) viol_back2back++;
            if (acc_write && avm_read) viol_overlap++;
            if (avm_read && acc_irq) viol_fetch_irq++;
            prev_wr = acc_write;
            if (acc_write) begin
                if (exp_acc.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL acc_unexpected: got write %h=%h, required none", acc_address, acc_writedata);
                end else begin
                    e = exp_acc.pop_front();
                    check("acc_address", {27'd0, acc_address}, {27'd0, e[36:32]});
                    check("acc_writedata", acc_writedata, e[31:0]);
                end
            end
            if (avm_read) begin
                if (prev_stall) check("avm_stall_addr", avm_address, stall_addr);
                if (avm_waitrequest) begin
                    if (!prev_stall) stall_addr = avm_address;
                    prev_stall = 1'b1;
                end else begin
                    prev_stall = 1'b0;
                    if (exp_avm.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL avm_unexpected: got read %h, required none", avm_address);
                    end else begin
                        check("avm_address", avm_address, exp_avm.pop_front());
                    end
                    if (avm_address[4:0] != 5'd0)
                        check("word_cycles", 32'(cyc - last_accept), 32'(2 + wait_states));
                    last_accept = cyc;
                end
            end else if (prev_stall) begin
                n_tests++; n_fail++;
                $display("FAIL avm_read_dropped: got avm_read 0 during stall, required 1");
                prev_stall = 1'b0;
            end
        end
    end

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        avs_address = a;
        #1;
        d = avs_readdata;
    endtask

    task automatic load_desc(input logic [31:0] addr, input logic [31:0] words [7]);
        for (int k = 0; k < 7; k++) begin
            mem[addr + 32'(4 * k)] = words[k];
            exp_avm.push_back(addr + 32'(4 * k));
            exp_acc.push_back({5'(4 * k), words[k]});
        end
        exp_acc.push_back({5'h1C, 32'd1});
        exp_acc.push_back({5'h1C, 32'd0});
    endtask

    task automatic wait_done(input string name);
        logic [31:0] s;
        int n;
        n = 0;
        csr_read(4'hC, s);
        while (s[1] == 1'b0 && n < 3000) begin
            @(posedge clk); #1;
            csr_read(4'hC, s);
            n++;
        end
        if (s[1] == 1'b0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got done 0 after %0d cycles, required 1", name, n);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL global_timeout: got no finish, required finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : main
        logic [31:0] r;
        logic [31:0] d0 [7];
        logic [31:0] d1 [7];
        d0 = '{32'hDEADBEEF, 32'hC01DCAFE, 32'hBADEC0DE, 32'h8BADF00D, 32'h0, 32'h100, 32'h80};
        d1 = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233, 32'h200, 32'h300, 32'h40};
        reset_n = 1'b0;
        avs_address = 4'd0; avs_write = 1'b0; avs_writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_avm_read", {31'd0, avm_read}, 32'd0);
        check("rst_avm_address", avm_address, 32'd0);
        check("rst_acc_write", {31'd0, acc_write}, 32'd0);
        check("rst_acc_address", {27'd0, acc_address}, 32'd0);
        check("rst_acc_writedata", acc_writedata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            csr_read(4'(4 * a), r);
            check("rst_csr", r, 32'd0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;

        csr_write(4'h0, 32'h0000_0400);
        csr_write(4'h4, 32'd1);
        load_desc(32'h400, d0);
        csr_write(4'h8, 32'h3);
        check("start_to_read", {31'd0, avm_read}, 32'd1);
        csr_write(4'h0, 32'hFFFF_FFF0);
        csr_write(4'h8, 32'h3);
        csr_read(4'h0, r);
        check("busy_base_ignored", r, 32'h0000_0400);
        csr_read(4'hC, r);
        check("busy_flag", {31'd0, r[0]}, 32'd1);
        wait_done("job1");
        csr_read(4'hC, r);
        check("job1_status", r, 32'h0001_0002);
        check("job1_irq", {31'd0, irq}, 32'd1);
        csr_write(4'h8, 32'h2);
        check("irq_clear", {31'd0, irq}, 32'd0);
        csr_read(4'hC, r);
        check("done_clear", r, 32'h0001_0000);

        csr_write(4'h4, 32'd2);
        load_desc(32'h400, d0);
        load_desc(32'h420, d1);
        csr_write(4'h8, 32'h3);
        wait_done("chain");
        csr_read(4'hC, r);
        check("chain_status", r, 32'h0002_0002);
        csr_write(4'h8, 32'h2);

        wait_states = 3;
        csr_write(4'h4, 32'd1);
        load_desc(32'h400, d0);
        csr_write(4'h8, 32'h3);
        check("ws_start_to_read", {31'd0, avm_read}, 32'd1);
        wait_done("waitstates");
        csr_read(4'hC, r);
        check("ws_status", r, 32'h0001_0002);
        wait_states = 0;

        csr_write(4'h4, 32'd0);
        csr_write(4'h8, 32'h3);
        csr_read(4'hC, r);
        check("cnt0_cycle1", r, 32'h0000_0001);
        @(posedge clk); #1;
        csr_read(4'hC, r);
        check("cnt0_done", r, 32'h0000_0002);
        check("cnt0_irq", {31'd0, irq}, 32'd1);
        csr_write(4'h8, 32'h0);

`ifdef ACCEL_SEQ_TIMEOUT_EN
        irq_never = 1'b1;
        csr_write(4'h4, 32'd1);
        load_desc(32'h400, d0);
        csr_write(4'h8, 32'h3);
        wait_done("timeout");
        csr_read(4'hC, r);
        check("timeout_status", r, 32'h0000_0006);
        repeat (2) @(posedge clk);
        #1;
        check("timeout_ack_issued", 32'(exp_acc.size()), 32'd0);
        irq_never = 1'b0;
        csr_write(4'h8, 32'h0);
`endif

        wait_states = 3;
        csr_write(4'h4, 32'd1);
        load_desc(32'h400, d0);
        csr_write(4'h8, 32'h3);
        check("pre_reset_read", {31'd0, avm_read}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_avm_read", {31'd0, avm_read}, 32'd0);
        check("async_avm_address", avm_address, 32'd0);
        check("async_acc_write", {31'd0, acc_write}, 32'd0);
        check("async_acc_writedata", acc_writedata, 32'd0);
        check("async_irq", {31'd0, irq}, 32'd0);
        csr_read(4'h0, r);
        check("async_base", r, 32'd0);
        csr_read(4'hC, r);
        check("async_status", r, 32'd0);
        exp_avm.delete();
        exp_acc.delete();
        wait_states = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        check("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
        check("avm_queue_empty", 32'(exp_avm.size()), 32'd0);
        check("acc_back_to_back", 32'(viol_back2back), 32'd0);
        check("read_write_overlap", 32'(viol_overlap), 32'd0);
        check("fetch_before_irq_drop", 32'(viol_fetch_irq), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
